// File: rtl/video_regs_pkg.sv
// Register map, ctrl-bit positions and FSM encodings shared by the
// mode loader and its config-sync handshake.
package video_regs_pkg;

    localparam int unsigned REG_RES_X       = 0;
    localparam int unsigned REG_RES_Y       = 1;
    localparam int unsigned REG_HSYNC_START = 2;
    localparam int unsigned REG_HSYNC_END   = 3;
    localparam int unsigned REG_HTOTAL      = 4;
    localparam int unsigned REG_VSYNC_START = 5;
    localparam int unsigned REG_VSYNC_END   = 6;
    localparam int unsigned REG_VTOTAL      = 7;
    localparam int unsigned REG_CTRL        = 8;
    localparam int unsigned REG_PIXFMT      = 9;
    localparam int unsigned REG_CURSOR      = 10;

    localparam int unsigned CTRL_SYNC       = 0;
    localparam int unsigned CTRL_SYNC_ACK   = 1;
    localparam int unsigned CTRL_TREGS_ACK  = 2;

    localparam int unsigned NUM_TIMING_REGS = 11;

    localparam logic [5:0] CTRL_ADDR = 6'(REG_CTRL << 2);

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_WRITE,
        LD_SYNC
    } load_state_t;

    typedef enum logic [2:0] {
        HS_IDLE,
        HS_SET,
        HS_WAIT_ACK,
        HS_CLR,
        HS_WAIT_NACK
    } hs_state_t;

    function automatic logic [31:0] ctrl_word(input logic tregs_ack, input logic sync);
        logic [31:0] w;
        w                 = '0;
        w[CTRL_TREGS_ACK] = tregs_ack;
        w[CTRL_SYNC]      = sync;
        return w;
    endfunction

endpackage

// File: rtl/cfg_sync_handshake.sv
// Config-sync handshake on the ctrl register: set sync, wait for ack,
// clear sync, wait for ack to drop; each wait bounded by a timeout.
module cfg_sync_handshake
    import video_regs_pkg::*;
#(
    parameter int unsigned TO_W = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic ack,
    output logic wr,
    output logic sync,
    output logic done,
    output logic err
);

    hs_state_t       state, state_next;
    logic [TO_W-1:0] timer;
    logic            timeout;

    assign timeout = (timer == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The write cycle counts as tick 0, so a timeout lands exactly 2**TO_W-1
    // cycles after SET (or CLR).
    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else begin
            case (state)
                HS_SET, HS_CLR:            timer <= TO_W'(1);
                HS_WAIT_ACK, HS_WAIT_NACK: timer <= timer + 1'b1;
                default:                   timer <= '0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HS_IDLE:      if (start) state_next = HS_SET;
            HS_SET:       state_next = HS_WAIT_ACK;
            HS_WAIT_ACK: begin
                if (ack)          state_next = HS_CLR;
                else if (timeout) state_next = HS_IDLE;
            end
            HS_CLR:       state_next = HS_WAIT_NACK;
            HS_WAIT_NACK: if (!ack || timeout) state_next = HS_IDLE;
            default:      state_next = HS_IDLE;
        endcase
    end

    always_comb begin
        wr   = 1'b0;
        sync = 1'b0;
        done = 1'b0;
        err  = 1'b0;
        case (state)
            HS_SET: begin
                wr   = 1'b1;
                sync = 1'b1;
            end
            HS_WAIT_ACK: begin
                if (!ack && timeout) begin
                    wr  = 1'b1;
                    err = 1'b1;
                end
            end
            HS_CLR:       wr = 1'b1;
            HS_WAIT_NACK: begin
                done = !ack;
                err  = ack && timeout;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/video_mode_loader.sv
// Writes a full mode descriptor to the video register port, then runs the
// config-sync handshake; arbitrates the port between MCU and sequencer.
module video_mode_loader
    import video_regs_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_TIMING_REGS,
    parameter int unsigned TO_W     = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           mcu_wdata,
    input  logic [5:0]            mcu_addr,
    input  logic                  mcu_wstrobe,
    output logic [31:0]           mcu_rdata,
    output logic                  mcu_busy,
    input  logic                  load_req,
    input  logic [32*NUM_REGS-1:0] mode_regs,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic [31:0]           v_wdata,
    output logic [5:0]            v_addr,
    output logic                  v_wstrobe,
    input  logic [31:0]           v_rdata
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    load_state_t state, state_next;
    logic [3:0]  idx;
    logic [31:0] snap [NUM_REGS];
    logic        pending;
    logic        shadow;
    logic        hs_start, hs_wr, hs_sync, hs_done, hs_err;

    assign hs_start  = (state == LD_WRITE) && (idx == LAST_IDX);
    assign mcu_rdata = v_rdata;

    cfg_sync_handshake #(.TO_W(TO_W)) u_sync (
        .clk   (clk),
        .reset (reset),
        .start (hs_start),
        .ack   (v_rdata[CTRL_SYNC_ACK]),
        .wr    (hs_wr),
        .sync  (hs_sync),
        .done  (hs_done),
        .err   (hs_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LD_IDLE;
            idx     <= '0;
            pending <= 1'b0;
            shadow  <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) snap[i] <= '0;
        end else begin
            state <= state_next;
            case (state)
                LD_IDLE: begin
                    if (mcu_wstrobe && mcu_addr[5:2] == 4'(REG_CTRL))
                        shadow <= mcu_wdata[CTRL_TREGS_ACK];
                    if (load_req || pending) begin
                        for (int unsigned i = 0; i < NUM_REGS; i++)
                            snap[i] <= mode_regs[32*i +: 32];
                        idx     <= '0;
                        pending <= 1'b0;
                    end
                end
                LD_WRITE: begin
                    idx <= idx + 1'b1;
                    if (load_req) pending <= 1'b1;
                end
                default: if (load_req) pending <= 1'b1;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LD_IDLE:  if (load_req || pending) state_next = LD_WRITE;
            LD_WRITE: if (idx == LAST_IDX) state_next = LD_SYNC;
            LD_SYNC:  if (hs_done || hs_err) state_next = LD_IDLE;
            default:  state_next = LD_IDLE;
        endcase
    end

    // Busy drops in the pulse cycle itself so a pending load starts right after.
    always_comb begin
        v_addr    = mcu_addr;
        v_wdata   = mcu_wdata;
        v_wstrobe = mcu_wstrobe;
        mcu_busy  = 1'b0;
        load_busy = 1'b0;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (state)
            LD_WRITE: begin
                v_addr    = {idx, 2'b00};
                v_wdata   = snap[idx];
                v_wstrobe = (idx != 4'(REG_CTRL));
                mcu_busy  = 1'b1;
                load_busy = 1'b1;
            end
            LD_SYNC: begin
                v_addr    = CTRL_ADDR;
                v_wdata   = ctrl_word(shadow, hs_sync);
                v_wstrobe = hs_wr;
                mcu_busy  = 1'b1;
                load_busy = !(hs_done || hs_err);
                load_done = hs_done;
                load_err  = hs_err;
            end
            default: ;
        endcase
    end

endmodule
